// File: rtl/looper_sram_ctrl.sv
// Loop-pedal SRAM sequencer: records post-effect samples to consecutive SRAM
// addresses and plays the loop back cyclically, mixed with live audio.
// Ports:
//   i_AUD_BCLK, i_rst_n          clock, async active-low reset
//   i_valid, i_data              one-cycle live sample strobe and sample
//   i_cmd_rec, i_cmd_stop        one-cycle mode command pulses
//   o_data, o_valid              output sample and one-cycle strobe
//   o_state                      0=IDLE, 1=RECORD, 2=PLAY
//   o_loop_len, o_full           committed loop length, recording hit MAX_LEN
//   o_SRAM_*, io_SRAM_DQ         external 16-bit SRAM interface (active-low strobes)
module looper_sram_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned MAX_LEN = 32'h000F_FFFF,
  parameter int unsigned ACC_CYC = 2
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [15:0]       i_data,
  input  logic              i_cmd_rec,
  input  logic              i_cmd_stop,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic [1:0]        o_state,
  output logic [ADDR_W-1:0] o_loop_len,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam int unsigned CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_CYC - 1);
  localparam logic [ADDR_W-1:0] LEN_MAX  = ADDR_W'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RECORD = 2'd1, ST_PLAY = 2'd2} mode_e;
  typedef enum logic [1:0] {ACC_IDLE = 2'd0, ACC_ACCESS = 2'd1, ACC_DONE = 2'd2} acc_e;

  mode_e             mode_q, mode_d;
  acc_e              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d, sram_addr_q, sram_addr_d;
  logic              full_q, full_d, pend_rec_q, pend_rec_d, pend_stop_q, pend_stop_d;
  logic [15:0]       sample_q, sample_d, odata_q, odata_d, dq_out_q, dq_out_d;
  logic              ovalid_q, ovalid_d, dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d, bn_n_q, bn_n_d;

  logic              cmd_en, cmd_rec, cmd_stop, auto_full;
  logic [ADDR_W-1:0] addr_inc, base_addr;

  // 17-bit signed sum clamped to the 16-bit range
  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) sat16 = s[16] ? 16'h8000 : 16'h7FFF;
    else                sat16 = s[15:0];
  endfunction

  // State register
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q      <= ST_IDLE;
      acc_q       <= ACC_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      full_q      <= 1'b0;
      sample_q    <= '0;
      pend_rec_q  <= 1'b0;
      pend_stop_q <= 1'b0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      bn_n_q      <= 1'b1;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      full_q      <= full_d;
      sample_q    <= sample_d;
      pend_rec_q  <= pend_rec_d;
      pend_stop_q <= pend_stop_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      bn_n_q      <= bn_n_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  // Access sequencer and mode FSM next-state
  always_comb begin
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    full_d      = full_q;
    sample_d    = sample_q;
    pend_rec_d  = pend_rec_q;
    pend_stop_d = pend_stop_q;
    odata_d     = odata_q;
    ovalid_d    = 1'b0;
    sram_addr_d = sram_addr_q;
    ce_n_d      = ce_n_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    bn_n_d      = bn_n_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    cmd_en      = 1'b0;
    cmd_rec     = 1'b0;
    cmd_stop    = 1'b0;
    auto_full   = 1'b0;
    addr_inc    = addr_q + ADDR_W'(1);
    base_addr   = addr_q;

    unique case (acc_q)
      ACC_IDLE: begin
        if (i_valid) sample_d = i_data;
        if (i_valid && (mode_q != ST_IDLE)) begin
          // Commands seen on the start cycle wait until the access retires
          acc_d       = ACC_ACCESS;
          cnt_d       = '0;
          sram_addr_d = addr_q;
          ce_n_d      = 1'b0;
          bn_n_d      = 1'b0;
          pend_rec_d  = i_cmd_rec;
          pend_stop_d = i_cmd_stop;
          if (mode_q == ST_RECORD) begin
            we_n_d   = 1'b0;
            dq_oe_d  = 1'b1;
            dq_out_d = i_data;
          end else begin
            oe_n_d = 1'b0;
          end
        end else begin
          if (i_valid) begin
            ovalid_d = 1'b1;
            odata_d  = i_data;
          end
          cmd_en   = 1'b1;
          cmd_rec  = i_cmd_rec;
          cmd_stop = i_cmd_stop;
        end
      end
      ACC_ACCESS: begin
        pend_rec_d  = pend_rec_q | i_cmd_rec;
        pend_stop_d = pend_stop_q | i_cmd_stop;
        if (cnt_q == CNT_LAST) begin
          acc_d    = ACC_DONE;
          ce_n_d   = 1'b1;
          we_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          bn_n_d   = 1'b1;
          dq_oe_d  = 1'b0;
          ovalid_d = 1'b1;
          odata_d  = (mode_q == ST_PLAY) ? sat16(sample_q, io_SRAM_DQ) : sample_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACC_DONE: begin
        acc_d       = ACC_IDLE;
        cmd_en      = 1'b1;
        cmd_rec     = pend_rec_q | i_cmd_rec;
        cmd_stop    = pend_stop_q | i_cmd_stop;
        pend_rec_d  = 1'b0;
        pend_stop_d = 1'b0;
        if (mode_q == ST_RECORD) begin
          if (addr_inc == LEN_MAX) begin
            auto_full = 1'b1;
            len_d     = LEN_MAX;
            full_d    = 1'b1;
            addr_d    = '0;
            mode_d    = ST_PLAY;
          end else begin
            addr_d = addr_inc;
          end
        end else if (mode_q == ST_PLAY) begin
          addr_d = (addr_q == len_q - ADDR_W'(1)) ? '0 : addr_inc;
        end
        base_addr = addr_d;
      end
      default: acc_d = ACC_IDLE;
    endcase

    // Command application; stop has priority, an auto-commit absorbs a rec
    if (cmd_en) begin
      if (cmd_stop) begin
        mode_d = ST_IDLE;
        addr_d = '0;
      end else if (cmd_rec && !auto_full) begin
        unique case (mode_q)
          ST_IDLE: begin
            mode_d = ST_RECORD;
            addr_d = '0;
            full_d = 1'b0;
          end
          ST_RECORD: begin
            if (base_addr == '0) begin
              mode_d = ST_IDLE;
            end else begin
              len_d  = base_addr;
              addr_d = '0;
              mode_d = ST_PLAY;
            end
          end
          ST_PLAY: begin
            mode_d = ST_IDLE;
            addr_d = '0;
          end
          default: mode_d = ST_IDLE;
        endcase
      end
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_data      = odata_q;
  assign o_valid     = ovalid_q;
  assign o_state     = mode_q;
  assign o_loop_len  = len_q;
  assign o_full      = full_q;
  assign o_SRAM_ADDR = sram_addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = bn_n_q;
  assign o_SRAM_UB_N = bn_n_q;

endmodule

// File: tb/tb_looper_sram_ctrl.sv
// Self-checking bench for looper_sram_ctrl: directed cases plus randomized
// record/play rounds checked against a loop-buffer reference model.
module tb_looper_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        cmd_rec = 1'b0, cmd_stop = 1'b0, cmd_rec3 = 1'b0;

  logic [15:0] o_data;
  logic        o_valid, o_full;
  logic [1:0]  o_state;
  logic [19:0] o_loop_len, sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;

  logic [15:0] o_data3;
  logic        o_valid3, o_full3;
  logic [1:0]  o_state3;
  logic [19:0] o_loop_len3, sram_addr3;
  wire  [15:0] sram_dq3;
  logic        we_n3, ce_n3, oe_n3, lb_n3, ub_n3;

  int n_checks = 0;
  int n_err = 0;

  looper_sram_ctrl dut (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_cmd_rec(cmd_rec), .i_cmd_stop(cmd_stop), .o_data(o_data), .o_valid(o_valid),
    .o_state(o_state), .o_loop_len(o_loop_len), .o_full(o_full),
    .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq), .o_SRAM_WE_N(we_n),
    .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  looper_sram_ctrl #(.MAX_LEN(3)) dut3 (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_cmd_rec(cmd_rec3), .i_cmd_stop(1'b0), .o_data(o_data3), .o_valid(o_valid3),
    .o_state(o_state3), .o_loop_len(o_loop_len3), .o_full(o_full3),
    .o_SRAM_ADDR(sram_addr3), .io_SRAM_DQ(sram_dq3), .o_SRAM_WE_N(we_n3),
    .o_SRAM_CE_N(ce_n3), .o_SRAM_OE_N(oe_n3), .o_SRAM_LB_N(lb_n3), .o_SRAM_UB_N(ub_n3)
  );

  always #5 clk = ~clk;

  // SRAM model and access logger
  logic [15:0] mem [0:63];
  logic [19:0] wr_log [0:511];
  logic [19:0] rd_log [0:511];
  int          run_log [0:511];
  int          wr_n = 0, rd_n = 0, run_n = 0, we_run = 0, ce_low = 0;
  logic        prev_we = 1'b1, prev_oe = 1'b1;

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;

  always @(negedge clk) begin
    prev_we <= we_n;
    prev_oe <= oe_n;
    if (!ce_n) ce_low <= ce_low + 1;
    if (!ce_n && !we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
      we_run <= we_run + 1;
      if (prev_we) begin
        wr_log[wr_n] <= sram_addr;
        wr_n <= wr_n + 1;
      end
    end else if (!prev_we) begin
      run_log[run_n] <= we_run;
      run_n <= run_n + 1;
      we_run <= 0;
    end
    if (!ce_n && !oe_n && prev_oe) begin
      rd_log[rd_n] <= sram_addr;
      rd_n <= rd_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference mix: saturating signed sum of stored and live samples
  function automatic logic [15:0] ref_mix(input logic [15:0] a, input logic [15:0] b);
    int v;
    v = int'($signed(a)) + int'($signed(b));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic pulse(input logic rec, input logic stop, input logic rec3);
    @(posedge clk); #1;
    cmd_rec = rec; cmd_stop = stop; cmd_rec3 = rec3;
    @(posedge clk); #1;
    cmd_rec = 1'b0; cmd_stop = 1'b0; cmd_rec3 = 1'b0;
    @(negedge clk);
  endtask

  // One sample frame: checks latency, data and single-cycle strobe width
  task automatic frame(input string tag, input logic [15:0] d, input int exp_lat,
                       input logic [15:0] exp_d);
    int lat;
    logic [15:0] od;
    lat = 0;
    od  = '0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = d;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = k;
        od  = o_data;
        break;
      end
      @(posedge clk);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(od), 32'(exp_d));
    @(negedge clk);
    chk({tag, "_vw"}, 32'(o_valid), 32'd0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] smp [$];
    logic [15:0] s, live;
    int n, m, idx, c0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_len", 32'(o_loop_len), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_strb", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1f);
    chk("rst_addr", 32'(sram_addr), 0);

    // Idle passthrough, no SRAM activity
    c0 = ce_low;
    frame("pass", 16'h1234, 1, 16'h1234);
    chk("pass_ce", 32'(ce_low), 32'(c0));

    // Commit with nothing recorded returns to idle
    pulse(1, 0, 0);
    chk("empty_rec_st", 32'(o_state), 1);
    pulse(1, 0, 0);
    chk("empty_st", 32'(o_state), 0);
    chk("empty_len", 32'(o_loop_len), 0);

    // MAX_LEN=3 instance: auto-commit on full, then rec leaves PLAY
    pulse(0, 0, 1);
    chk("full_rec_st", 32'(o_state3), 1);
    for (int i = 0; i < 3; i++) frame("full_pass", 16'(100 + i), 1, 16'(100 + i));
    chk("full_flag", 32'(o_full3), 1);
    chk("full_st", 32'(o_state3), 2);
    chk("full_len", 32'(o_loop_len3), 3);
    pulse(0, 0, 1);
    chk("full_exit_st", 32'(o_state3), 0);

    // Record 10,20,30,40
    pulse(1, 0, 0);
    chk("rec_st", 32'(o_state), 1);
    for (int i = 0; i < 4; i++) begin
      frame("rec", 16'(10 * (i + 1)), 3, 16'(10 * (i + 1)));
      chk("rec_waddr", 32'(wr_log[wr_n - 1]), 32'(i));
      chk("rec_werun", 32'(run_log[run_n - 1]), 2);
    end
    pulse(1, 0, 0);
    chk("rec_len", 32'(o_loop_len), 4);
    chk("play_st", 32'(o_state), 2);

    // Cyclic playback with live 1
    for (int j = 0; j < 6; j++) begin
      frame("play", 16'd1, 3, 16'(10 * ((j % 4) + 1) + 1));
      chk("play_raddr", 32'(rd_log[rd_n - 1]), 32'(j % 4));
    end

    // Saturation both directions
    pulse(0, 1, 0);
    chk("stop_st", 32'(o_state), 0);
    chk("stop_len", 32'(o_loop_len), 4);
    pulse(1, 0, 0);
    frame("sat_rec", 16'd30000, 3, 16'd30000);
    frame("sat_rec", 16'(-30000), 3, 16'(-30000));
    pulse(1, 0, 0);
    chk("sat_len", 32'(o_loop_len), 2);
    frame("sat_pos", 16'd10000, 3, 16'h7FFF);
    frame("sat_neg", 16'(-10000), 3, 16'h8000);

    // Stop and rec together mid-write: write completes, then idle
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 16'd77;
    @(posedge clk); #1;
    i_valid = 1'b0; cmd_stop = 1'b1; cmd_rec = 1'b1;
    @(posedge clk); #1;
    cmd_stop = 1'b0; cmd_rec = 1'b0;
    @(negedge clk);
    chk("hz_we_low", 32'(we_n), 0);
    chk("hz_st_hold", 32'(o_state), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("hz_st", 32'(o_state), 0);
    chk("hz_werun", 32'(run_log[run_n - 1]), 2);
    chk("hz_len", 32'(o_loop_len), 2);

    // Randomized record/play rounds against the loop-buffer model
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(8, 1);
      m = $urandom_range(2 * n + 2, n + 1);
      smp.delete();
      pulse(1, 0, 0);
      chk("rnd_rec_st", 32'(o_state), 1);
      for (int i = 0; i < n; i++) begin
        s = 16'($urandom);
        smp.push_back(s);
        frame("rnd_wr", s, 3, s);
        chk("rnd_waddr", 32'(wr_log[wr_n - 1]), 32'(i));
      end
      pulse(1, 0, 0);
      chk("rnd_len", 32'(o_loop_len), 32'(n));
      chk("rnd_play_st", 32'(o_state), 2);
      idx = 0;
      for (int j = 0; j < m; j++) begin
        live = 16'($urandom);
        frame("rnd_rd", live, 3, ref_mix(smp[idx], live));
        chk("rnd_raddr", 32'(rd_log[rd_n - 1]), 32'(idx));
        idx = (idx + 1) % n;
      end
      if (r < 4) begin
        pulse(0, 1, 0);
        chk("rnd_stop_st", 32'(o_state), 0);
      end
    end

    // Reset in the middle of a read
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 16'd5;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("rr_oe_low", 32'(oe_n), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_oe", 32'(oe_n), 1);
    chk("rr_ce", 32'(ce_n), 1);
    chk("rr_st", 32'(o_state), 0);
    chk("rr_len", 32'(o_loop_len), 0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
